// File: rtl/osd_stm_depacketizer_if.sv
// osd_stm_depacketizer_if
//   Bundles the DII flit input and the decoded-event output of the STM
//   depacketizer.
//   slave  : depacketizer view (consumes flits, produces events)
//   master : environment view (drives flits, sinks events)
//   Signals:
//     debug_in        {valid, last, data[15:0]} incoming DII flit
//     debug_in_ready  flit accepted when debug_in.valid && debug_in_ready
//     event_valid     decoded event present
//     event_ready     sink accepts event when event_valid && event_ready
//     event_timestamp / event_id / event_value / event_overflow / event_src
interface osd_stm_depacketizer_if #(
  parameter int unsigned XLEN = 64
);
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit_t;

  dii_flit_t        debug_in;
  logic             debug_in_ready;
  logic             event_valid;
  logic             event_ready;
  logic [31:0]      event_timestamp;
  logic [15:0]      event_id;
  logic [XLEN-1:0]  event_value;
  logic             event_overflow;
  logic [15:0]      event_src;

  modport slave (
    input  debug_in, event_ready,
    output debug_in_ready, event_valid, event_timestamp, event_id,
           event_value, event_overflow, event_src
  );

  modport master (
    output debug_in, event_ready,
    input  debug_in_ready, event_valid, event_timestamp, event_id,
           event_value, event_overflow, event_src
  );
endinterface

// File: rtl/osd_stm_depacketizer.sv
// osd_stm_depacketizer
//   Receive side of the STM trace path: parses DII event packets
//   (dest, src, flags, payload LSB word first) and rebuilds
//   {timestamp, id, value} trace events or overflow notices, one event per
//   packet, held in a one-entry output register.
//   Ports:
//     clk        clock
//     rst        asynchronous active-high reset
//     bus        osd_stm_depacketizer_if.slave (DII input + event output)
//     err_count  malformed-packet counter, saturating (only when
//                OSD_STM_DEPACK_ERRCNT_EN is defined)
//   Parameter: XLEN trace value width, multiple of 16 in 16..64.
//   Optional feature macro: OSD_STM_DEPACK_ERRCNT_EN.
module osd_stm_depacketizer #(
  parameter int unsigned XLEN = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  osd_stm_depacketizer_if.slave   bus
`ifdef OSD_STM_DEPACK_ERRCNT_EN
  ,
  output logic [15:0]             err_count
`endif
);
  localparam int unsigned NPW = (48 + XLEN) / 16;
  localparam logic [2:0]  LAST_WORD = 3'(NPW - 1);

  typedef enum logic [2:0] {
    ST_DEST,
    ST_SRC,
    ST_FLAGS,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_cnt;
  logic             r_is_ovf;
  logic [31:0]      r_ts;
  logic [15:0]      r_id;
  logic [15:0]      r_src;
  logic [XLEN-1:0]  r_val;

  logic             r_ev_valid;
  logic [31:0]      r_ev_ts;
  logic [15:0]      r_ev_id;
  logic [XLEN-1:0]  r_ev_value;
  logic             r_ev_ovf;
  logic [15:0]      r_ev_src;

  logic             w_accept;
  logic             w_last;
  logic [15:0]      w_data;
  logic             w_final;
  logic             w_type_ok;
  logic             w_load;
  logic [XLEN-1:0]  w_value;

  assign w_accept  = bus.debug_in.valid && !r_ev_valid;
  assign w_last    = bus.debug_in.last;
  assign w_data    = bus.debug_in.data;
  assign w_final   = r_is_ovf ? (r_cnt == 3'd0) : (r_cnt == LAST_WORD);
  assign w_type_ok = (w_data[15:14] == 2'b10) &&
                     ((w_data[13:10] == 4'h0) || (w_data[13:10] == 4'h5));

  // Value words are shifted in from the top, so after the last value word the
  // assembled value is right-aligned without a variable part-select.
  always_comb begin
    w_value = '0;
    if (r_is_ovf) begin
      w_value[15:0] = w_data;
    end else begin
      w_value = XLEN'({w_data, r_val} >> 16);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_DEST:    w_state_nxt = w_last ? ST_DEST : ST_SRC;
        ST_SRC:     w_state_nxt = w_last ? ST_DEST : ST_FLAGS;
        ST_FLAGS: begin
          if (w_last)          w_state_nxt = ST_DEST;
          else if (!w_type_ok) w_state_nxt = ST_DROP;
          else                 w_state_nxt = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (w_final) begin
            w_state_nxt = w_last ? ST_DEST : ST_DROP;
            w_load      = w_last;
          end else if (w_last) begin
            w_state_nxt = ST_DEST;
          end
        end
        ST_DROP:    w_state_nxt = w_last ? ST_DEST : ST_DROP;
        default:    w_state_nxt = ST_DEST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_DEST;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_ovf <= 1'b0;
      r_ts     <= '0;
      r_id     <= '0;
      r_src    <= '0;
      r_val    <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_SRC:   r_src <= w_data;
        ST_FLAGS: begin
          r_is_ovf <= (w_data[13:10] == 4'h5);
          r_cnt    <= '0;
        end
        ST_PAYLOAD: begin
          r_cnt <= r_cnt + 3'd1;
          if (!r_is_ovf) begin
            case (r_cnt)
              3'd0:    r_ts[15:0]  <= w_data;
              3'd1:    r_ts[31:16] <= w_data;
              3'd2:    r_id        <= w_data;
              default: r_val       <= w_value;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Flits are only accepted while the holding register is empty, so a load
  // never coincides with the sink handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ev_valid <= 1'b0;
      r_ev_ts    <= '0;
      r_ev_id    <= '0;
      r_ev_value <= '0;
      r_ev_ovf   <= 1'b0;
      r_ev_src   <= '0;
    end else if (w_load) begin
      r_ev_valid <= 1'b1;
      r_ev_ts    <= r_is_ovf ? 32'd0 : r_ts;
      r_ev_id    <= r_is_ovf ? 16'd0 : r_id;
      r_ev_value <= w_value;
      r_ev_ovf   <= r_is_ovf;
      r_ev_src   <= r_src;
    end else if (r_ev_valid && bus.event_ready) begin
      r_ev_valid <= 1'b0;
    end
  end

  assign bus.debug_in_ready  = !r_ev_valid;
  assign bus.event_valid     = r_ev_valid;
  assign bus.event_timestamp = r_ev_ts;
  assign bus.event_id        = r_ev_id;
  assign bus.event_value     = r_ev_value;
  assign bus.event_overflow  = r_ev_ovf;
  assign bus.event_src       = r_ev_src;

`ifdef OSD_STM_DEPACK_ERRCNT_EN
  // Malformed: early last before the final payload word, or missing last on
  // it. Packets dropped for an unsupported type are not counted.
  logic        w_malformed;
  logic [15:0] r_err_count;

  always_comb begin
    w_malformed = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_DEST, ST_SRC, ST_FLAGS: w_malformed = w_last;
        ST_PAYLOAD:                w_malformed = w_final ? !w_last : w_last;
        default:                   w_malformed = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_err_count <= '0;
    else if (w_malformed && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
  end

  assign err_count = r_err_count;
`endif

endmodule
